stepper_ramp_ctrl: RTL and testbench



---
 rtl/stepper_ramp_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_stepper_ramp_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stepper_ramp_ctrl.sv
// Stepper phase sequencer with an internal step-rate generator and a symmetric
// trapezoidal ramp; runs relative moves with a Start/Done handshake.
//
// state    | meaning
// S_IDLE   | no move; Start accepted while enabled
// S_ACCEL  | period shrinking by AccDelta per step towards the cruise period
// S_CRUISE | stepping at the cruise period
// S_DECEL  | period growing by AccDelta per step back towards the start period
module stepper_ramp_ctrl #(
   parameter int POS_W = 16,
   parameter int PER_W = 16
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             enable_i,
   input  logic             hold_torque_i,
   input  logic             start_i,
   input  logic             dir_i,
   input  logic [1:0]       mode_i,
   input  logic [POS_W-1:0] step_count_i,
   input  logic [PER_W-1:0] start_period_i,
   input  logic [PER_W-1:0] min_period_i,
   input  logic [PER_W-1:0] acc_delta_i,
   input  logic             abort_i,
   output logic [3:0]       phase_o,
   output logic             phase_oe_o,
   output logic [POS_W-1:0] position_o,
   output logic             ready_o,
   output logic             busy_o,
   output logic             done_o
);

   typedef enum logic [1:0] {S_IDLE, S_ACCEL, S_CRUISE, S_DECEL} state_t;

   state_t           state_q, state_d;
   logic [2:0]       idx_q, idx_d;
   logic [3:0]       phase_q, phase_d;
   logic [POS_W-1:0] pos_q, pos_d, rem_q, rem_d, acc_q, acc_d;
   logic [PER_W-1:0] period_q, period_d, cnt_q, cnt_d;
   logic [PER_W-1:0] ps_q, ps_d, pm_q, pm_d, delta_q, delta_d;
   logic             dir_q, dir_d, busy_q, busy_d, done_q, done_d;
   logic [1:0]       mode_q, mode_d;

   logic [PER_W-1:0] max_in, ps_in, pm_in, per_acc, per_dec, per_nxt;
   logic [PER_W:0]   up_sum, dn_lim;
   logic [POS_W-1:0] rem_dec, acc_inc, rem_abort, pos_step;
   logic [2:0]       mag, idx_step;
   logic             aligned, tc;

   function automatic logic [3:0] phase_lut(input logic [2:0] idx);
      case (idx)
         3'd0:    return 4'b0110;
         3'd1:    return 4'b0010;
         3'd2:    return 4'b1010;
         3'd3:    return 4'b1000;
         3'd4:    return 4'b1001;
         3'd5:    return 4'b0001;
         3'd6:    return 4'b0101;
         default: return 4'b0100;
      endcase
   endfunction

   assign max_in = (start_period_i > min_period_i) ? start_period_i : min_period_i;
   assign ps_in  = (max_in == '0) ? PER_W'(1) : max_in;
   assign pm_in  = (min_period_i == '0) ? PER_W'(1) : min_period_i;

   assign up_sum  = {1'b0, period_q} + {1'b0, delta_q};
   assign dn_lim  = {1'b0, pm_q} + {1'b0, delta_q};
   assign per_dec = (up_sum >= {1'b0, ps_q}) ? ps_q : up_sum[PER_W-1:0];
   assign per_acc = ({1'b0, period_q} >= dn_lim) ? (period_q - delta_q) : pm_q;

   assign tc      = (cnt_q <= PER_W'(1));
   assign rem_dec = rem_q - POS_W'(1);
   assign acc_inc = acc_q + POS_W'(1);

   // A misaligned index takes a single half-step to reach the mode's parity.
   always_comb begin
      case (mode_q)
         2'b01:   aligned = 1'b1;
         2'b10:   aligned = idx_q[0];
         default: aligned = ~idx_q[0];
      endcase
   end

   assign mag      = ((mode_q == 2'b01) || !aligned) ? 3'd1 : 3'd2;
   assign idx_step = dir_q ? (idx_q + mag) : (idx_q - mag);
   assign pos_step = dir_q ? (pos_q + POS_W'(mag)) : (pos_q - POS_W'(mag));

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      pos_d     = pos_q;
      rem_d     = rem_q;
      acc_d     = acc_q;
      period_d  = period_q;
      cnt_d     = cnt_q;
      ps_d      = ps_q;
      pm_d      = pm_q;
      delta_d   = delta_q;
      dir_d     = dir_q;
      mode_d    = mode_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      rem_abort = '0;
      per_nxt   = period_q;

      if (state_q == S_IDLE) begin
         if (start_i && enable_i) begin
            dir_d   = dir_i;
            mode_d  = mode_i;
            ps_d    = ps_in;
            pm_d    = pm_in;
            delta_d = acc_delta_i;
            if (step_count_i == '0) begin
               done_d = 1'b1;
            end else begin
               period_d = ps_in;
               cnt_d    = ps_in - PER_W'(1);
               rem_d    = step_count_i;
               acc_d    = '0;
               busy_d   = 1'b1;
               state_d  = S_ACCEL;
            end
         end
      end else if (!enable_i || (rem_q == '0)) begin
         state_d = S_IDLE;
         busy_d  = 1'b0;
         done_d  = 1'b1;
      end else if (abort_i && (state_q != S_DECEL)) begin
         // Stretch the running interval so it ends one decel period after the last step.
         period_d = per_dec;
         state_d  = S_DECEL;
         if (tc) begin
            idx_d     = idx_step;
            pos_d     = pos_step;
            rem_abort = (rem_dec < acc_q) ? rem_dec : acc_q;
            cnt_d     = per_dec;
         end else begin
            rem_abort = (rem_q < acc_q) ? rem_q : acc_q;
            cnt_d     = cnt_q - PER_W'(1) + (per_dec - period_q);
         end
         rem_d = rem_abort;
         if (rem_abort == '0) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
         end
      end else if (tc) begin
         idx_d = idx_step;
         pos_d = pos_step;
         rem_d = rem_dec;
         case (state_q)
            S_ACCEL: begin
               acc_d = acc_inc;
               if (rem_dec <= acc_inc) begin
                  state_d = S_DECEL;
                  per_nxt = per_dec;
               end else begin
                  per_nxt = per_acc;
                  if ((per_acc == pm_q) || (delta_q == '0)) state_d = S_CRUISE;
               end
            end
            S_CRUISE: begin
               if (rem_dec <= acc_q) begin
                  state_d = S_DECEL;
                  per_nxt = per_dec;
               end
            end
            default: per_nxt = per_dec;
         endcase
         period_d = per_nxt;
         cnt_d    = per_nxt;
      end else begin
         cnt_d = cnt_q - PER_W'(1);
      end

      phase_d = phase_lut(idx_d);
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         phase_q  <= 4'b0110;
         pos_q    <= '0;
         rem_q    <= '0;
         acc_q    <= '0;
         period_q <= '0;
         cnt_q    <= '0;
         ps_q     <= '0;
         pm_q     <= '0;
         delta_q  <= '0;
         dir_q    <= 1'b0;
         mode_q   <= 2'b00;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         phase_q  <= phase_d;
         pos_q    <= pos_d;
         rem_q    <= rem_d;
         acc_q    <= acc_d;
         period_q <= period_d;
         cnt_q    <= cnt_d;
         ps_q     <= ps_d;
         pm_q     <= pm_d;
         delta_q  <= delta_d;
         dir_q    <= dir_d;
         mode_q   <= mode_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign phase_o    = phase_q;
   assign position_o = pos_q;
   assign busy_o     = busy_q;
   assign ready_o    = ~busy_q;
   assign done_o     = done_q;
   assign phase_oe_o = enable_i & (busy_q | hold_torque_i);

endmodule

// File: tb/tb_stepper_ramp_ctrl.sv
// Bench for stepper_ramp_ctrl: a table of single moves with hand-computed step
// times, positions and phases, then ramp, abort, enable and reset sequences.
module tb_stepper_ramp_ctrl;
   localparam int POS_W = 16;
   localparam int PER_W = 16;

   logic             clk = 1'b0;
   logic             reset_i, enable_i, hold_torque_i, start_i, dir_i, abort_i;
   logic [1:0]       mode_i;
   logic [POS_W-1:0] step_count_i;
   logic [PER_W-1:0] start_period_i, min_period_i, acc_delta_i;
   logic [3:0]       phase_o;
   logic             phase_oe_o, ready_o, busy_o, done_o;
   logic [POS_W-1:0] position_o;

   stepper_ramp_ctrl #(.POS_W(POS_W), .PER_W(PER_W)) dut (
      .clk_i          (clk),
      .reset_i        (reset_i),
      .enable_i       (enable_i),
      .hold_torque_i  (hold_torque_i),
      .start_i        (start_i),
      .dir_i          (dir_i),
      .mode_i         (mode_i),
      .step_count_i   (step_count_i),
      .start_period_i (start_period_i),
      .min_period_i   (min_period_i),
      .acc_delta_i    (acc_delta_i),
      .abort_i        (abort_i),
      .phase_o        (phase_o),
      .phase_oe_o     (phase_oe_o),
      .position_o     (position_o),
      .ready_o        (ready_o),
      .busy_o         (busy_o),
      .done_o         (done_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // step times are offsets from the accept cycle N (first step of period P at N+P)
   int step_t[$];
   int step_ph[$];
   int done_t, busy1, oe1, dpos;

   task automatic run_move(input int m, input int d, input int cnt, input int sp,
                           input int mp, input int ad, input int abort_at,
                           input int disen_at, input int restart_at);
      int c, off;
      logic [POS_W-1:0] pos0, prev;
      bit ab, de, rs;
      step_t.delete();
      step_ph.delete();
      done_t = -1;
      ab = 0; de = 0; rs = 0;
      pos0 = position_o;
      prev = position_o;
      c = cyc;
      mode_i = 2'(m);
      dir_i = 1'(d);
      step_count_i = POS_W'(cnt);
      start_period_i = PER_W'(sp);
      min_period_i = PER_W'(mp);
      acc_delta_i = PER_W'(ad);
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      busy1 = int'(busy_o);
      oe1 = int'(phase_oe_o);
      for (int k = 0; k < 3000; k++) begin
         off = cyc - c;
         abort_i = 1'b0;
         start_i = 1'b0;
         if (position_o != prev) begin
            step_t.push_back(off);
            step_ph.push_back(int'(phase_o));
            prev = position_o;
         end
         if (done_o) begin
            done_t = off;
            break;
         end
         if (!ab && abort_at >= 0 && step_t.size() == abort_at) begin
            abort_i = 1'b1;
            ab = 1;
         end
         if (!de && disen_at >= 0 && step_t.size() == disen_at) begin
            enable_i = 1'b0;
            de = 1;
         end
         if (!rs && restart_at >= 0 && step_t.size() == restart_at) begin
            start_i = 1'b1;
            step_count_i = POS_W'(7);
            rs = 1;
         end
         @(negedge clk);
      end
      abort_i = 1'b0;
      start_i = 1'b0;
      if (done_t < 0) chk("done_timeout", 0, 1);
      dpos = int'($signed(position_o)) - int'($signed(pos0));
   endtask

   typedef struct {
      int mode, dir, cnt, sp, mp, ad;
      int exp_busy1, exp_nsteps, exp_first, exp_done, exp_dpos, exp_ph1, exp_phf;
   } vec_t;

   vec_t vecs[7];
   int ramp_e[10];
   int tri_e[3];
   int abort_e[4];
   int last_ph;

   initial begin
      vecs[0] = '{1, 1, 3, 4, 4, 0,  1, 3, 4, 13,  3, 2, 8};
      vecs[1] = '{1, 0, 2, 4, 4, 0,  1, 2, 4,  9, -2, 10, 2};
      vecs[2] = '{0, 0, 2, 4, 4, 0,  1, 2, 4,  9, -3, 6, 5};
      vecs[3] = '{2, 1, 2, 3, 5, 0,  1, 2, 5, 11,  3, 4, 2};
      vecs[4] = '{3, 1, 3, 2, 0, 1,  1, 3, 2,  6,  5, 10, 5};
      vecs[5] = '{1, 1, 0, 4, 4, 0,  0, 0, 0,  1,  0, 0, 5};
      vecs[6] = '{1, 1, 1, 6, 2, 10, 1, 1, 6,  7,  1, 4, 4};
      ramp_e  = '{10, 18, 24, 28, 32, 36, 40, 46, 54, 64};
      tri_e   = '{10, 18, 28};
      abort_e = '{10, 18, 26, 36};

      reset_i = 1'b1; enable_i = 1'b1; hold_torque_i = 1'b0; start_i = 1'b0;
      dir_i = 1'b1; abort_i = 1'b0; mode_i = 2'b01; step_count_i = '0;
      start_period_i = '0; min_period_i = '0; acc_delta_i = '0;
      repeat (3) @(negedge clk);
      reset_i = 1'b0;
      @(negedge clk);
      chk("rst_phase", int'(phase_o), 6);
      chk("rst_oe", int'(phase_oe_o), 0);
      chk("rst_pos", int'(position_o), 0);
      chk("rst_ready", int'(ready_o), 1);
      chk("rst_busy", int'(busy_o), 0);
      chk("rst_done", int'(done_o), 0);

      for (int i = 0; i < 7; i++) begin
         run_move(vecs[i].mode, vecs[i].dir, vecs[i].cnt, vecs[i].sp, vecs[i].mp,
                  vecs[i].ad, -1, -1, -1);
         chk($sformatf("v%0d_busy1", i), busy1, vecs[i].exp_busy1);
         chk($sformatf("v%0d_oe1", i), oe1, vecs[i].exp_busy1);
         chk($sformatf("v%0d_nsteps", i), step_t.size(), vecs[i].exp_nsteps);
         if (vecs[i].exp_nsteps > 0 && step_t.size() > 0) begin
            chk($sformatf("v%0d_first_t", i), step_t[0], vecs[i].exp_first);
            chk($sformatf("v%0d_first_ph", i), step_ph[0], vecs[i].exp_ph1);
         end
         chk($sformatf("v%0d_done_t", i), done_t, vecs[i].exp_done);
         chk($sformatf("v%0d_dpos", i), dpos, vecs[i].exp_dpos);
         chk($sformatf("v%0d_phase", i), int'(phase_o), vecs[i].exp_phf);
         chk($sformatf("v%0d_ready", i), int'(ready_o), 1);
      end

      // trapezoid: 10 steps from index 7 forward
      run_move(1, 1, 10, 10, 4, 2, -1, -1, -1);
      chk("ramp_nsteps", step_t.size(), 10);
      for (int i = 0; i < 10; i++)
         if (i < step_t.size()) chk($sformatf("ramp_t%0d", i), step_t[i], ramp_e[i]);
      chk("ramp_done_t", done_t, 65);
      chk("ramp_phase", int'(phase_o), 2);

      // triangle: never reaches cruise
      run_move(1, 1, 3, 10, 4, 2, -1, -1, -1);
      chk("tri_nsteps", step_t.size(), 3);
      for (int i = 0; i < 3; i++)
         if (i < step_t.size()) chk($sformatf("tri_t%0d", i), step_t[i], tri_e[i]);
      chk("tri_done_t", done_t, 29);
      chk("tri_phase", int'(phase_o), 9);

      // abort just after the second step of a reverse ramp
      run_move(1, 0, 10, 10, 4, 2, 2, -1, -1);
      chk("abort_nsteps", step_t.size(), 4);
      for (int i = 0; i < 4; i++)
         if (i < step_t.size()) chk($sformatf("abort_t%0d", i), step_t[i], abort_e[i]);
      chk("abort_done_t", done_t, 37);
      chk("abort_dpos", dpos, -4);
      chk("abort_phase", int'(phase_o), 6);

      // drop Enable after the first step
      run_move(1, 1, 10, 10, 4, 2, -1, 1, -1);
      chk("dis_nsteps", step_t.size(), 1);
      chk("dis_done_t", done_t, 11);
      chk("dis_oe", int'(phase_oe_o), 0);
      chk("dis_busy", int'(busy_o), 0);
      chk("dis_phase", int'(phase_o), 2);
      last_ph = int'(phase_o);
      hold_torque_i = 1'b1;
      enable_i = 1'b1;
      @(negedge clk);
      chk("hold_oe", int'(phase_oe_o), 1);
      chk("hold_done", int'(done_o), 0);
      repeat (4) @(negedge clk);
      chk("hold_phase", int'(phase_o), last_ph);
      chk("hold_busy", int'(busy_o), 0);

      // Start with Enable low is ignored
      hold_torque_i = 1'b0;
      enable_i = 1'b0;
      step_count_i = POS_W'(5);
      start_period_i = PER_W'(4);
      min_period_i = PER_W'(4);
      acc_delta_i = '0;
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      chk("noen_busy", int'(busy_o), 0);
      chk("noen_done", int'(done_o), 0);
      chk("noen_oe", int'(phase_oe_o), 0);
      enable_i = 1'b1;
      @(negedge clk);
      chk("noen_ready", int'(ready_o), 1);

      // Start while busy is ignored; Done lasts one cycle
      run_move(1, 1, 4, 4, 4, 0, -1, -1, 1);
      chk("rstart_nsteps", step_t.size(), 4);
      chk("rstart_done_t", done_t, 17);
      chk("rstart_phase", int'(phase_o), 1);
      @(negedge clk);
      chk("done_width", int'(done_o), 0);
      chk("post_busy", int'(busy_o), 0);

      // Reset in the middle of a move
      mode_i = 2'b01;
      dir_i = 1'b1;
      step_count_i = POS_W'(5);
      start_period_i = PER_W'(4);
      min_period_i = PER_W'(4);
      acc_delta_i = '0;
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      repeat (5) @(negedge clk);
      chk("mid_busy", int'(busy_o), 1);
      reset_i = 1'b1;
      @(negedge clk);
      reset_i = 1'b0;
      chk("mrst_pos", int'(position_o), 0);
      chk("mrst_phase", int'(phase_o), 6);
      chk("mrst_busy", int'(busy_o), 0);
      chk("mrst_ready", int'(ready_o), 1);
      chk("mrst_oe", int'(phase_oe_o), 0);
      chk("mrst_done", int'(done_o), 0);
      @(negedge clk);
      chk("mrst_done2", int'(done_o), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
